ssd1306_command_decoder: RTL and testbench

Upstream stage of the VGA SSD1306 replica. It accepts an SSD1306-style byte stream with a data/command flag, interprets the supported command subset, and writes display bytes into the frame-buffer RAM that the VGA scanout reads by RequestedAddress. The frame buffer is 128 columns × 12 pages (96 rows), addressed as page*128 + column on 11 bits. The block also exports the display-on, invert and contrast state for the scanout.

---
 rtl/ssd1306_command_decoder.sv | 198 +++++++++++++++++++
 tb/tb_ssd1306_command_decoder.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/ssd1306_command_decoder.sv
// SSD1306 byte-stream decoder: applies the supported command subset and writes display bytes to the frame buffer.
// Writes appear 1 cycle after accept; Ready_o drops for the WRITE cycle (and the power-up sweep when SSD1306_CLEAR_EN is defined).
module ssd1306_command_decoder #(
    parameter int COLUMNS = 128,
    parameter int PAGES   = 12
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [7:0]  Data_i,
    input  logic        DataCommand_i,
    input  logic        Valid_i,
    output logic        Ready_o,
    output logic [10:0] RamAddress_o,
    output logic [7:0]  RamData_o,
    output logic        RamWrite_o,
    output logic        DisplayOn_o,
    output logic        Invert_o,
    output logic [7:0]  Contrast_o
);

    localparam logic [3:0] MAX_PAGE = 4'(PAGES - 1);
    localparam logic [6:0] MAX_COL  = 7'(COLUMNS - 1);
    localparam logic [1:0] MODE_H   = 2'b00;
    localparam logic [1:0] MODE_V   = 2'b01;
    localparam logic [1:0] MODE_P   = 2'b10;

    typedef enum logic [2:0] {S_CMD, S_ARG1, S_ARG2, S_WRITE, S_CLEAR} state_t;

`ifdef SSD1306_CLEAR_EN
    localparam state_t     RST_STATE = S_CLEAR;
    localparam logic       RST_READY = 1'b0;
    localparam logic [10:0] CLR_LAST = 11'(PAGES * COLUMNS - 1);
    logic [10:0] clr_q, clr_d;
    logic        clr_done_q, clr_done_d;
`else
    localparam state_t     RST_STATE = S_CMD;
    localparam logic       RST_READY = 1'b1;
`endif

    state_t      state_q, state_d;
    logic [7:0]  cmd_q, cmd_d;
    logic [6:0]  arg_q, arg_d;
    logic [6:0]  col_q, col_d, col_start_q, col_start_d, col_end_q, col_end_d;
    logic [3:0]  page_q, page_d, page_start_q, page_start_d, page_end_q, page_end_d;
    logic [1:0]  mode_q, mode_d;
    logic        ready_q, ready_d, wr_q, wr_d, disp_q, disp_d, inv_q, inv_d;
    logic [10:0] addr_q, addr_d;
    logic [7:0]  wdat_q, wdat_d, contrast_q, contrast_d;
    logic        accept;
    logic [3:0]  data_page;

    function automatic logic [3:0] clamp_page(input logic [7:0] v);
        if (v > {4'd0, MAX_PAGE}) return MAX_PAGE;
        return v[3:0];
    endfunction

    assign accept    = Valid_i && ready_q;
    assign data_page = clamp_page(Data_i);

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) state_q <= RST_STATE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_CMD: if (accept) begin
                if (DataCommand_i) state_d = S_WRITE;
                else if (Data_i == 8'h81 || Data_i == 8'h20 || Data_i == 8'h21 || Data_i == 8'h22)
                    state_d = S_ARG1;
            end
            S_ARG1: if (accept) begin
                if (DataCommand_i) state_d = S_WRITE;
                else if (cmd_q == 8'h21 || cmd_q == 8'h22) state_d = S_ARG2;
                else state_d = S_CMD;
            end
            S_ARG2: if (accept) state_d = DataCommand_i ? S_WRITE : S_CMD;
            S_WRITE: state_d = S_CMD;
`ifdef SSD1306_CLEAR_EN
            S_CLEAR: if (clr_done_q) state_d = S_CMD;
`endif
            default: state_d = S_CMD;
        endcase
    end

    always_comb begin
        cmd_d = cmd_q;         arg_d = arg_q;
        col_d = col_q;         page_d = page_q;
        col_start_d = col_start_q;   col_end_d = col_end_q;
        page_start_d = page_start_q; page_end_d = page_end_q;
        mode_d = mode_q;       disp_d = disp_q;   inv_d = inv_q;
        contrast_d = contrast_q;
        addr_d = addr_q;       wdat_d = wdat_q;   wr_d = 1'b0;
        ready_d = (state_d != S_WRITE) && (state_d != S_CLEAR);
`ifdef SSD1306_CLEAR_EN
        clr_d = clr_q;         clr_done_d = clr_done_q;
`endif
        case (state_q)
            S_CMD, S_ARG1, S_ARG2: if (accept) begin
                if (DataCommand_i) begin
                    wr_d   = 1'b1;
                    addr_d = {page_q, col_q};
                    wdat_d = Data_i;
                end else if (state_q == S_CMD) begin
                    cmd_d = Data_i;
                    casez (Data_i)
                        8'b0000_????: col_d[3:0] = Data_i[3:0];
                        8'b0001_0???: col_d[6:4] = Data_i[2:0];
                        8'b1011_????: page_d = clamp_page({4'd0, Data_i[3:0]});
                        8'hAE, 8'hAF: disp_d = Data_i[0];
                        8'hA6, 8'hA7: inv_d = Data_i[0];
                        default: ;
                    endcase
                end else if (state_q == S_ARG1) begin
                    case (cmd_q)
                        8'h81: contrast_d = Data_i;
                        8'h20: if (Data_i[1:0] != 2'b11) mode_d = Data_i[1:0];
                        8'h21: arg_d = Data_i[6:0];
                        8'h22: arg_d = {3'd0, data_page};
                        default: ;
                    endcase
                end else begin
                    // Second argument commits the whole window; ends below start snap to start.
                    if (cmd_q == 8'h21) begin
                        col_start_d = arg_q;
                        col_end_d   = (Data_i[6:0] < arg_q) ? arg_q : Data_i[6:0];
                        col_d       = arg_q;
                    end else if (cmd_q == 8'h22) begin
                        page_start_d = arg_q[3:0];
                        page_end_d   = (data_page < arg_q[3:0]) ? arg_q[3:0] : data_page;
                        page_d       = arg_q[3:0];
                    end
                end
            end
            S_WRITE: begin
                case (mode_q)
                    MODE_H: if (col_q == col_end_q) begin
                        col_d  = col_start_q;
                        page_d = (page_q == page_end_q) ? page_start_q : page_q + 4'd1;
                    end else col_d = col_q + 7'd1;
                    MODE_V: if (page_q == page_end_q) begin
                        page_d = page_start_q;
                        col_d  = (col_q == col_end_q) ? col_start_q : col_q + 7'd1;
                    end else page_d = page_q + 4'd1;
                    default: col_d = (col_q == col_end_q) ? col_start_q : col_q + 7'd1;
                endcase
            end
`ifdef SSD1306_CLEAR_EN
            S_CLEAR: if (!clr_done_q) begin
                wr_d   = 1'b1;
                addr_d = clr_q;
                wdat_d = 8'h00;
                clr_d  = clr_q + 11'd1;
                if (clr_q == CLR_LAST) clr_done_d = 1'b1;
            end
`endif
            default: ;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            cmd_q <= 8'h00;        arg_q <= 7'd0;
            col_q <= 7'd0;         page_q <= 4'd0;
            col_start_q <= 7'd0;   col_end_q <= MAX_COL;
            page_start_q <= 4'd0;  page_end_q <= MAX_PAGE;
            mode_q <= MODE_P;      disp_q <= 1'b0;   inv_q <= 1'b0;
            contrast_q <= 8'h7F;
            addr_q <= 11'd0;       wdat_q <= 8'h00;  wr_q <= 1'b0;
            ready_q <= RST_READY;
`ifdef SSD1306_CLEAR_EN
            clr_q <= 11'd0;        clr_done_q <= 1'b0;
`endif
        end else begin
            cmd_q <= cmd_d;        arg_q <= arg_d;
            col_q <= col_d;        page_q <= page_d;
            col_start_q <= col_start_d;   col_end_q <= col_end_d;
            page_start_q <= page_start_d; page_end_q <= page_end_d;
            mode_q <= mode_d;      disp_q <= disp_d; inv_q <= inv_d;
            contrast_q <= contrast_d;
            addr_q <= addr_d;      wdat_q <= wdat_d; wr_q <= wr_d;
            ready_q <= ready_d;
`ifdef SSD1306_CLEAR_EN
            clr_q <= clr_d;        clr_done_q <= clr_done_d;
`endif
        end
    end

    assign Ready_o      = ready_q;
    assign RamAddress_o = addr_q;
    assign RamData_o    = wdat_q;
    assign RamWrite_o   = wr_q;
    assign DisplayOn_o  = disp_q;
    assign Invert_o     = inv_q;
    assign Contrast_o   = contrast_q;

endmodule

// File: tb/tb_ssd1306_command_decoder.sv
// Directed bench for ssd1306_command_decoder: command subset, addressing modes, abort and throughput.
module tb_ssd1306_command_decoder;

    logic        Clock = 1'b0;
    logic        Reset = 1'b0;
    logic [7:0]  Data_i = 8'h00;
    logic        DataCommand_i = 1'b0;
    logic        Valid_i = 1'b0;
    logic        Ready_o;
    logic [10:0] RamAddress_o;
    logic [7:0]  RamData_o;
    logic        RamWrite_o;
    logic        DisplayOn_o;
    logic        Invert_o;
    logic [7:0]  Contrast_o;

    int checks = 0;
    int failures = 0;
    logic [18:0] wq[$];

`ifdef SSD1306_CLEAR_EN
    localparam logic RST_READY = 1'b0;
`else
    localparam logic RST_READY = 1'b1;
`endif

    ssd1306_command_decoder dut (
        .Clock(Clock), .Reset(Reset), .Data_i(Data_i), .DataCommand_i(DataCommand_i),
        .Valid_i(Valid_i), .Ready_o(Ready_o), .RamAddress_o(RamAddress_o),
        .RamData_o(RamData_o), .RamWrite_o(RamWrite_o), .DisplayOn_o(DisplayOn_o),
        .Invert_o(Invert_o), .Contrast_o(Contrast_o)
    );

    always #20 Clock = ~Clock;

    always @(negedge Clock) if (RamWrite_o) wq.push_back({RamAddress_o, RamData_o});

    task automatic idle(input int n);
        repeat (n) @(negedge Clock);
    endtask

    task automatic send(input logic dc, input logic [7:0] b);
        int n = 0;
        @(negedge Clock);
        while (!Ready_o && n < 50) begin @(negedge Clock); n++; end
        if (!Ready_o) begin
            checks++; failures++;
            $display("FAIL send_timeout ready=%b required=1", Ready_o);
        end
        Valid_i = 1'b1; DataCommand_i = dc; Data_i = b;
        @(posedge Clock); #1;
        Valid_i = 1'b0;
    endtask

    task automatic test_reset;
        Reset = 1'b0;
        idle(3);
        checks++; if (Ready_o !== RST_READY) begin failures++; $display("FAIL rst_ready got=%b exp=%b", Ready_o, RST_READY); end
        checks++; if (RamWrite_o !== 1'b0) begin failures++; $display("FAIL rst_write got=%b exp=0", RamWrite_o); end
        checks++; if (RamAddress_o !== 11'd0) begin failures++; $display("FAIL rst_addr got=%0d exp=0", RamAddress_o); end
        checks++; if (RamData_o !== 8'h00) begin failures++; $display("FAIL rst_data got=%h exp=00", RamData_o); end
        checks++; if (DisplayOn_o !== 1'b0) begin failures++; $display("FAIL rst_disp got=%b exp=0", DisplayOn_o); end
        checks++; if (Invert_o !== 1'b0) begin failures++; $display("FAIL rst_inv got=%b exp=0", Invert_o); end
        checks++; if (Contrast_o !== 8'h7F) begin failures++; $display("FAIL rst_contrast got=%h exp=7f", Contrast_o); end
        Reset = 1'b1;
    endtask

`ifdef SSD1306_CLEAR_EN
    task automatic test_clear;
        int n = 0;
        int bad = 0;
        while (wq.size() < 700 && n < 2000) begin @(negedge Clock); n++; end
        Reset = 1'b0; #1;
        checks++; if (RamWrite_o !== 1'b0 || Ready_o !== 1'b0) begin failures++; $display("FAIL clr_abort wr=%b rdy=%b exp 0 0", RamWrite_o, Ready_o); end
        @(negedge Clock);
        wq.delete();
        Reset = 1'b1;
        n = 0;
        while (!Ready_o && n < 3000) begin @(negedge Clock); n++; end
        checks++; if (!Ready_o) begin failures++; $display("FAIL clr_timeout ready=%b exp=1", Ready_o); end
        checks++; if (wq.size() != 1536) begin failures++; $display("FAIL clr_count got=%0d exp=1536", wq.size()); end
        foreach (wq[i]) if (wq[i] !== {11'(i), 8'h00}) bad++;
        checks++; if (bad != 0) begin failures++; $display("FAIL clr_sequence bad_entries=%0d exp=0", bad); end
        wq.delete();
    endtask
`endif

    task automatic test_data_write;
        wq.delete();
        send(1'b1, 8'hA5);
        @(negedge Clock);
        checks++; if (RamWrite_o !== 1'b1) begin failures++; $display("FAIL dw_strobe got=%b exp=1", RamWrite_o); end
        checks++; if (RamAddress_o !== 11'd0) begin failures++; $display("FAIL dw_addr got=%0d exp=0", RamAddress_o); end
        checks++; if (RamData_o !== 8'hA5) begin failures++; $display("FAIL dw_data got=%h exp=a5", RamData_o); end
        checks++; if (Ready_o !== 1'b0) begin failures++; $display("FAIL dw_ready_low got=%b exp=0", Ready_o); end
        @(negedge Clock);
        checks++; if (RamWrite_o !== 1'b0) begin failures++; $display("FAIL dw_strobe_end got=%b exp=0", RamWrite_o); end
        checks++; if (Ready_o !== 1'b1) begin failures++; $display("FAIL dw_ready_high got=%b exp=1", Ready_o); end
        send(1'b1, 8'h3C);
        idle(3);
        checks++; if (wq.size() != 2) begin failures++; $display("FAIL dw_count got=%0d exp=2", wq.size()); end
        else begin
            checks++; if (wq[1] !== {11'd1, 8'h3C}) begin failures++; $display("FAIL dw_second got=%0d/%h exp=1/3c", wq[1][18:8], wq[1][7:0]); end
        end
    endtask

    task automatic test_window;
        logic [18:0] exp_w [3];
        exp_w = '{{11'd1534, 8'h11}, {11'd1535, 8'h22}, {11'd1534, 8'h33}};
        wq.delete();
        send(1'b0, 8'h20); send(1'b0, 8'h00);
        send(1'b0, 8'h21); send(1'b0, 8'h7E); send(1'b0, 8'h7F);
        send(1'b0, 8'h22); send(1'b0, 8'h0B); send(1'b0, 8'h0B);
        send(1'b1, 8'h11); send(1'b1, 8'h22); send(1'b1, 8'h33);
        idle(3);
        checks++; if (wq.size() != 3) begin failures++; $display("FAIL win_count got=%0d exp=3", wq.size()); end
        else for (int i = 0; i < 3; i++) begin
            checks++; if (wq[i] !== exp_w[i]) begin failures++; $display("FAIL win_write%0d got=%0d/%h exp=%0d/%h", i, wq[i][18:8], wq[i][7:0], exp_w[i][18:8], exp_w[i][7:0]); end
        end
    endtask

    task automatic test_clamp;
        wq.delete();
        send(1'b0, 8'h00); send(1'b0, 8'h10);
        send(1'b0, 8'h22); send(1'b0, 8'h14); send(1'b0, 8'h02);
        send(1'b1, 8'h77);
        idle(3);
        checks++; if (wq.size() != 1) begin failures++; $display("FAIL clamp_count got=%0d exp=1", wq.size()); end
        else begin
            checks++; if (wq[0] !== {11'd1408, 8'h77}) begin failures++; $display("FAIL clamp_write got=%0d/%h exp=1408/77", wq[0][18:8], wq[0][7:0]); end
        end
    endtask

    task automatic test_abort;
        wq.delete();
        send(1'b0, 8'h81); send(1'b1, 8'h55);
        idle(3);
        checks++; if (Contrast_o !== 8'h7F) begin failures++; $display("FAIL abort_contrast got=%h exp=7f", Contrast_o); end
        checks++; if (wq.size() != 1) begin failures++; $display("FAIL abort_count got=%0d exp=1", wq.size()); end
        else begin
            checks++; if (wq[0] !== {11'd1409, 8'h55}) begin failures++; $display("FAIL abort_write got=%0d/%h exp=1409/55", wq[0][18:8], wq[0][7:0]); end
        end
        send(1'b0, 8'hA7);
        idle(1);
        checks++; if (Invert_o !== 1'b1 || Contrast_o !== 8'h7F) begin failures++; $display("FAIL abort_cmd_state inv=%b con=%h exp=1/7f", Invert_o, Contrast_o); end
    endtask

    task automatic test_regs;
        wq.delete();
        send(1'b0, 8'hA6);
        send(1'b0, 8'hAF); send(1'b0, 8'hA7);
        send(1'b0, 8'h81); send(1'b0, 8'h30); send(1'b0, 8'hE3);
        idle(2);
        checks++; if (DisplayOn_o !== 1'b1) begin failures++; $display("FAIL regs_disp got=%b exp=1", DisplayOn_o); end
        checks++; if (Invert_o !== 1'b1) begin failures++; $display("FAIL regs_inv got=%b exp=1", Invert_o); end
        checks++; if (Contrast_o !== 8'h30) begin failures++; $display("FAIL regs_contrast got=%h exp=30", Contrast_o); end
        checks++; if (wq.size() != 0 || Ready_o !== 1'b1) begin failures++; $display("FAIL regs_noop writes=%0d rdy=%b exp=0/1", wq.size(), Ready_o); end
        send(1'b0, 8'hAE); send(1'b0, 8'hA6);
        idle(1);
        checks++; if (DisplayOn_o !== 1'b0 || Invert_o !== 1'b0) begin failures++; $display("FAIL regs_clear disp=%b inv=%b exp=0/0", DisplayOn_o, Invert_o); end
    endtask

    task automatic test_modes;
        logic [10:0] exp_a [7];
        exp_a = '{11'd389, 11'd390, 11'd389, 11'd389, 11'd517, 11'd390, 11'd518};
        wq.delete();
        send(1'b0, 8'h20); send(1'b0, 8'h02);
        send(1'b0, 8'h21); send(1'b0, 8'h05); send(1'b0, 8'h06);
        send(1'b0, 8'h22); send(1'b0, 8'h03); send(1'b0, 8'h04);
        send(1'b1, 8'h01); send(1'b1, 8'h02); send(1'b1, 8'h03);
        send(1'b0, 8'h20); send(1'b0, 8'h01);
        send(1'b0, 8'h21); send(1'b0, 8'h05); send(1'b0, 8'h06);
        send(1'b0, 8'h22); send(1'b0, 8'h03); send(1'b0, 8'h04);
        send(1'b1, 8'h04); send(1'b1, 8'h05); send(1'b1, 8'h06);
        send(1'b0, 8'h20); send(1'b0, 8'h03);
        send(1'b1, 8'h07);
        idle(3);
        checks++; if (wq.size() != 7) begin failures++; $display("FAIL modes_count got=%0d exp=7", wq.size()); end
        else for (int i = 0; i < 7; i++) begin
            checks++; if (wq[i] !== {exp_a[i], 8'(i + 1)}) begin failures++; $display("FAIL modes_write%0d got=%0d/%h exp=%0d/%h", i, wq[i][18:8], wq[i][7:0], exp_a[i], 8'(i + 1)); end
        end
    endtask

    task automatic test_back_to_back;
        logic [18:0] exp_w [4];
        exp_w = '{{11'd389, 8'h40}, {11'd517, 8'h42}, {11'd390, 8'h44}, {11'd518, 8'h46}};
        wq.delete();
        @(negedge Clock);
        Valid_i = 1'b1; DataCommand_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            Data_i = 8'(8'h40 + i);
            @(negedge Clock);
        end
        Valid_i = 1'b0;
        idle(3);
        checks++; if (wq.size() != 4) begin failures++; $display("FAIL b2b_count got=%0d exp=4", wq.size()); end
        else for (int i = 0; i < 4; i++) begin
            checks++; if (wq[i] !== exp_w[i]) begin failures++; $display("FAIL b2b_write%0d got=%0d/%h exp=%0d/%h", i, wq[i][18:8], wq[i][7:0], exp_w[i][18:8], exp_w[i][7:0]); end
        end
    endtask

    initial begin
        test_reset();
`ifdef SSD1306_CLEAR_EN
        test_clear();
`endif
        test_data_write();
        test_window();
        test_clamp();
        test_abort();
        test_regs();
        test_modes();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
